// File: rtl/tpram_ctrl_pkg.sv
// Shared constants and types for the TPRAM write-side control logic.
package tpram_ctrl_pkg;

    localparam int TPRAM_AW    = 12;
    localparam int TPRAM_DW    = 32;
    localparam int DWORD_IDX_W = 10;

    localparam logic [1:0] MODE_DWORD = 2'b00;
    localparam logic [1:0] MODE_WORD  = 2'b01;
    localparam logic [1:0] MODE_BYTE  = 2'b10;
    localparam logic [1:0] MODE_RESV  = 2'b11;

    // ST_IDLE | waiting for START
    // ST_RUN  | streaming math-block results into consecutive dwords
    // ST_DONE | transfer finished (or stopped on pointer wrap)
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mb_state_e;

endpackage

// File: rtl/tpram_wr_rr_arb.sv
// Two-way combinational grant between the eFPGA requester and the math block,
// round-robin on ties unless MB_PRIO forces the math block to win.
module tpram_wr_rr_arb #(
    parameter int MB_PRIO = 0
) (
    input  logic EFPGA_TPRAM_W_CLK,
    input  logic EFPGA_TPRAM_W_RST,
    input  logic ef_req,
    input  logic mb_req,
    output logic ef_gnt,
    output logic mb_gnt
);

    logic last_mb;
    logic tie_mb;

    always_comb begin
        tie_mb = (MB_PRIO != 0) || !last_mb;
        ef_gnt = ef_req && (!mb_req || !tie_mb);
        mb_gnt = mb_req && (!ef_req || tie_mb);
    end

    // Requests are already valid-qualified, so a grant is an accept.
    always_ff @(posedge EFPGA_TPRAM_W_CLK) begin
        if (EFPGA_TPRAM_W_RST) begin
            last_mb <= 1'b1;
        end else if (ef_gnt) begin
            last_mb <= 1'b0;
        end else if (mb_gnt) begin
            last_mb <= 1'b1;
        end
    end

endmodule

// File: rtl/tpram_wr_arb.sv
// TPRAM write-port arbiter: eFPGA requests and a math-block result stream.
// Optional macro TPRAM_WR_ARB_WRAP_ERR_EN: stop with MB_ERR on dword-pointer wrap.
module tpram_wr_arb
    import tpram_ctrl_pkg::*;
#(
    parameter int MB_PRIO = 0
) (
    input  logic                   EFPGA_TPRAM_W_CLK,
    input  logic                   EFPGA_TPRAM_W_RST,
    input  logic                   EF_REQ_VALID,
    output logic                   EF_REQ_READY,
    input  logic [TPRAM_AW-1:0]    EF_REQ_ADDR,
    input  logic [1:0]             EF_REQ_MODE,
    input  logic [TPRAM_DW-1:0]    EF_REQ_DATA,
    input  logic                   MB_WR_VALID,
    output logic                   MB_WR_READY,
    input  logic [TPRAM_DW-1:0]    MB_WR_DATA,
    input  logic                   CFG_MB_START,
    input  logic                   CFG_MB_ABORT,
    input  logic [DWORD_IDX_W-1:0] CFG_MB_BASE,
    input  logic [DWORD_IDX_W-1:0] CFG_MB_LEN,
    output logic                   MB_BUSY,
    output logic                   MB_DONE,
    output logic                   MB_ERR,
    output logic                   EFPGA_TPRAM_WE,
    output logic                   EFPGA_TPRAM_WDSEL,
    output logic [1:0]             EFPGA_TPRAM_W_MODE,
    output logic [TPRAM_AW-1:0]    EFPGA_TPRAM_W_ADDR,
    output logic [TPRAM_DW-1:0]    EFPGA_TPRAM_W_DATA,
    output logic [TPRAM_DW-1:0]    MATHB_TPRAM_W_DATA
);

    mb_state_e              state;
    logic [DWORD_IDX_W-1:0] ptr;
    logic [DWORD_IDX_W-1:0] rem;
    logic                   ef_req;
    logic                   mb_req;
    logic                   ef_gnt;
    logic                   mb_gnt;

    // Gating with reset keeps both READYs low and blocks accepts during reset.
    assign ef_req = EF_REQ_VALID && !EFPGA_TPRAM_W_RST;
    assign mb_req = MB_WR_VALID && (state == ST_RUN) && !CFG_MB_ABORT && !EFPGA_TPRAM_W_RST;

    tpram_wr_rr_arb #(
        .MB_PRIO(MB_PRIO)
    ) u_rr_arb (
        .EFPGA_TPRAM_W_CLK(EFPGA_TPRAM_W_CLK),
        .EFPGA_TPRAM_W_RST(EFPGA_TPRAM_W_RST),
        .ef_req           (ef_req),
        .mb_req           (mb_req),
        .ef_gnt           (ef_gnt),
        .mb_gnt           (mb_gnt)
    );

    assign EF_REQ_READY = ef_gnt;
    assign MB_WR_READY  = mb_gnt;

`ifdef TPRAM_WR_ARB_WRAP_ERR_EN
    logic err_q;
    assign MB_ERR = err_q;
`else
    assign MB_ERR = 1'b0;
`endif

    always_ff @(posedge EFPGA_TPRAM_W_CLK) begin
        if (EFPGA_TPRAM_W_RST) begin
            state              <= ST_IDLE;
            ptr                <= '0;
            rem                <= '0;
            MB_BUSY            <= 1'b0;
            MB_DONE            <= 1'b0;
            EFPGA_TPRAM_WE     <= 1'b0;
            EFPGA_TPRAM_WDSEL  <= 1'b0;
            EFPGA_TPRAM_W_MODE <= MODE_DWORD;
            EFPGA_TPRAM_W_ADDR <= '0;
            EFPGA_TPRAM_W_DATA <= '0;
            MATHB_TPRAM_W_DATA <= '0;
`ifdef TPRAM_WR_ARB_WRAP_ERR_EN
            err_q              <= 1'b0;
`endif
        end else begin
            EFPGA_TPRAM_WE <= ef_gnt || mb_gnt;
            if (ef_gnt) begin
                EFPGA_TPRAM_WDSEL  <= 1'b0;
                EFPGA_TPRAM_W_MODE <= EF_REQ_MODE;
                EFPGA_TPRAM_W_ADDR <= EF_REQ_ADDR;
                EFPGA_TPRAM_W_DATA <= EF_REQ_DATA;
            end else if (mb_gnt) begin
                EFPGA_TPRAM_WDSEL  <= 1'b1;
                EFPGA_TPRAM_W_MODE <= MODE_DWORD;
                EFPGA_TPRAM_W_ADDR <= {ptr, 2'b00};
                MATHB_TPRAM_W_DATA <= MB_WR_DATA;
            end

            if (CFG_MB_ABORT) begin
                state   <= ST_IDLE;
                MB_BUSY <= 1'b0;
                MB_DONE <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (CFG_MB_START) begin
                            ptr <= CFG_MB_BASE;
                            rem <= CFG_MB_LEN;
`ifdef TPRAM_WR_ARB_WRAP_ERR_EN
                            err_q <= 1'b0;
`endif
                            if (CFG_MB_LEN == '0) begin
                                state   <= ST_DONE;
                                MB_BUSY <= 1'b0;
                                MB_DONE <= 1'b1;
                            end else begin
                                state   <= ST_RUN;
                                MB_BUSY <= 1'b1;
                                MB_DONE <= 1'b0;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (mb_gnt) begin
                            ptr <= ptr + 10'd1;
                            rem <= rem - 10'd1;
                            if (rem == 10'd1) begin
                                state   <= ST_DONE;
                                MB_BUSY <= 1'b0;
                                MB_DONE <= 1'b1;
                            end
`ifdef TPRAM_WR_ARB_WRAP_ERR_EN
                            // Last dword written; more data would wrap to 0.
                            else if (ptr == '1) begin
                                state   <= ST_DONE;
                                MB_BUSY <= 1'b0;
                                MB_DONE <= 1'b1;
                                err_q   <= 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        MB_BUSY <= 1'b0;
                        MB_DONE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpram_wr_arb.sv
// Scoreboard bench for tpram_wr_arb; a second instance covers MB_PRIO=1.
module tb_tpram_wr_arb;

    logic        clk;
    logic        rst;
    logic        ef_valid, ef_ready;
    logic [11:0] ef_addr;
    logic [1:0]  ef_mode;
    logic [31:0] ef_data;
    logic        mb_valid, mb_ready;
    logic [31:0] mb_data;
    logic        start, abort;
    logic [9:0]  base, len;
    logic        busy, done, err;
    logic        we, wdsel;
    logic [1:0]  wmode;
    logic [11:0] waddr;
    logic [31:0] wdata, mdata;

    logic        p1_ef_valid, p1_ef_ready, p1_mb_valid, p1_mb_ready;
    logic        p1_start, p1_busy, p1_done, p1_err, p1_we, p1_wdsel;
    logic [9:0]  p1_len;
    logic [1:0]  p1_wmode;
    logic [11:0] p1_waddr;
    logic [31:0] p1_wdata, p1_mdata;

    tpram_wr_arb #(.MB_PRIO(0)) u_dut (
        .EFPGA_TPRAM_W_CLK (clk),
        .EFPGA_TPRAM_W_RST (rst),
        .EF_REQ_VALID      (ef_valid),
        .EF_REQ_READY      (ef_ready),
        .EF_REQ_ADDR       (ef_addr),
        .EF_REQ_MODE       (ef_mode),
        .EF_REQ_DATA       (ef_data),
        .MB_WR_VALID       (mb_valid),
        .MB_WR_READY       (mb_ready),
        .MB_WR_DATA        (mb_data),
        .CFG_MB_START      (start),
        .CFG_MB_ABORT      (abort),
        .CFG_MB_BASE       (base),
        .CFG_MB_LEN        (len),
        .MB_BUSY           (busy),
        .MB_DONE           (done),
        .MB_ERR            (err),
        .EFPGA_TPRAM_WE    (we),
        .EFPGA_TPRAM_WDSEL (wdsel),
        .EFPGA_TPRAM_W_MODE(wmode),
        .EFPGA_TPRAM_W_ADDR(waddr),
        .EFPGA_TPRAM_W_DATA(wdata),
        .MATHB_TPRAM_W_DATA(mdata)
    );

    tpram_wr_arb #(.MB_PRIO(1)) u_dut_p1 (
        .EFPGA_TPRAM_W_CLK (clk),
        .EFPGA_TPRAM_W_RST (rst),
        .EF_REQ_VALID      (p1_ef_valid),
        .EF_REQ_READY      (p1_ef_ready),
        .EF_REQ_ADDR       (12'h020),
        .EF_REQ_MODE       (2'b00),
        .EF_REQ_DATA       (32'h0000_0055),
        .MB_WR_VALID       (p1_mb_valid),
        .MB_WR_READY       (p1_mb_ready),
        .MB_WR_DATA        (32'h0000_0066),
        .CFG_MB_START      (p1_start),
        .CFG_MB_ABORT      (1'b0),
        .CFG_MB_BASE       (10'd0),
        .CFG_MB_LEN        (p1_len),
        .MB_BUSY           (p1_busy),
        .MB_DONE           (p1_done),
        .MB_ERR            (p1_err),
        .EFPGA_TPRAM_WE    (p1_we),
        .EFPGA_TPRAM_WDSEL (p1_wdsel),
        .EFPGA_TPRAM_W_MODE(p1_wmode),
        .EFPGA_TPRAM_W_ADDR(p1_waddr),
        .EFPGA_TPRAM_W_DATA(p1_wdata),
        .MATHB_TPRAM_W_DATA(p1_mdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wdsel;
        logic [1:0]  mode;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_writes = 0;

`ifdef TPRAM_WR_ARB_WRAP_ERR_EN
    localparam int   WRAP_N   = 2;
    localparam logic WRAP_ERR = 1'b1;
`else
    localparam int   WRAP_N   = 4;
    localparam logic WRAP_ERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push_exp(input logic s, input logic [1:0] m, input logic [11:0] a,
                            input logic [31:0] d);
        wr_t e;
        e.wdsel = s; e.mode = m; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented write is matched against the oldest expectation.
    always @(negedge clk) begin
        if (we) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr=%h wdsel=%b, required no write",
                         waddr, wdsel);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_wdsel", {31'd0, wdsel}, {31'd0, mon_e.wdsel});
                chk("wr_mode", {30'd0, wmode}, {30'd0, mon_e.mode});
                chk("wr_addr", {20'd0, waddr}, {20'd0, mon_e.addr});
                chk("wr_data", wdsel ? mdata : wdata, mon_e.data);
            end
        end
    end

    task automatic tick(output logic ea, output logic ma);
        @(negedge clk);
        ea = ef_valid && ef_ready;
        ma = mb_valid && mb_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] b, input logic [9:0] l);
        logic ea, ma;
        base = b; len = l; start = 1'b1;
        tick(ea, ma);
        start = 1'b0;
    endtask

    task automatic run_mb(input int n_exp, input int budget, input logic [31:0] d0,
                          output int got, output int cyc);
        logic ea, ma;
        got = 0; cyc = 0;
        mb_valid = 1'b1; mb_data = d0;
        while (got < n_exp && cyc < budget) begin
            tick(ea, ma);
            cyc++;
            if (ma) begin
                got++;
                mb_data = d0 + got;
            end
        end
        mb_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic ea, ma;
        tick(ea, ma);
        tick(ea, ma);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    logic ea, ma;
    int   got, cyc, w0;
    logic exp_ef[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        ef_valid = 1'b1; ef_addr = 12'h111; ef_mode = 2'b00; ef_data = 32'hDEAD_BEEF;
        mb_valid = 1'b1; mb_data = 32'h0;
        start = 1'b1; abort = 1'b0; base = 10'h3; len = 10'd5;
        p1_ef_valid = 1'b0; p1_mb_valid = 1'b0; p1_start = 1'b0; p1_len = 10'd0;

        // Reset state with requests and START held active.
        tick(ea, ma);
        tick(ea, ma);
        @(negedge clk);
        chk("rst_ef_ready", {31'd0, ef_ready}, 0);
        chk("rst_mb_ready", {31'd0, mb_ready}, 0);
        chk("rst_we", {31'd0, we}, 0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
        chk("rst_waddr", {20'd0, waddr}, 0);
        @(posedge clk); #1;
        rst = 1'b0; ef_valid = 1'b0; mb_valid = 1'b0; start = 1'b0;
        tick(ea, ma);
        chk("post_rst_we", {31'd0, we}, 0);
        chk("post_rst_busy", {31'd0, busy}, 0);

        // Four back-to-back math beats from dword 0x100.
        for (int k = 0; k < 4; k++) push_exp(1'b1, 2'b00, 12'h400 + 12'(4 * k), 32'hD000_0000 + k);
        do_start(10'h100, 10'd4);
        chk("run_busy", {31'd0, busy}, 1);
        run_mb(4, 20, 32'hD000_0000, got, cyc);
        chk("b2b_beats", got, 4);
        chk("b2b_cycles", cyc, 4);
        chk("b2b_done", {30'd0, busy, done}, 32'd1);
        drain("b2b_drain");

        // eFPGA writes, including reserved mode passed through.
        push_exp(1'b0, 2'b10, 12'h013, 32'h0000_00A5);
        push_exp(1'b0, 2'b11, 12'h7FE, 32'h1234_5678);
        ef_valid = 1'b1; ef_addr = 12'h013; ef_mode = 2'b10; ef_data = 32'h0000_00A5;
        tick(ea, ma);
        chk("ef_acc0", {31'd0, ea}, 1);
        ef_addr = 12'h7FE; ef_mode = 2'b11; ef_data = 32'h1234_5678;
        tick(ea, ma);
        chk("ef_acc1", {31'd0, ea}, 1);
        ef_valid = 1'b0;
        drain("ef_drain");

        // Round-robin tie-break after a fresh reset: EF, MB, EF, MB, then EF alone.
        rst = 1'b1;
        tick(ea, ma);
        rst = 1'b0;
        push_exp(1'b0, 2'b00, 12'h100, 32'hE000_0000);
        push_exp(1'b1, 2'b00, 12'h040, 32'hC000_0000);
        push_exp(1'b0, 2'b00, 12'h104, 32'hE000_0001);
        push_exp(1'b1, 2'b00, 12'h044, 32'hC000_0001);
        push_exp(1'b0, 2'b00, 12'h108, 32'hE000_0002);
        do_start(10'h010, 10'd2);
        ef_valid = 1'b1; ef_mode = 2'b00; ef_addr = 12'h100; ef_data = 32'hE000_0000;
        mb_valid = 1'b1; mb_data = 32'hC000_0000;
        for (int i = 0; i < 5; i++) begin
            tick(ea, ma);
            chk($sformatf("rr_ef_c%0d", i), {31'd0, ea}, {31'd0, exp_ef[i]});
            chk($sformatf("rr_mb_c%0d", i), {31'd0, ma}, {31'd0, !exp_ef[i]});
            if (ea) begin
                ef_addr = ef_addr + 12'd4;
                ef_data = ef_data + 32'd1;
            end
            if (ma) mb_data = mb_data + 32'd1;
        end
        ef_valid = 1'b0; mb_valid = 1'b0;
        chk("rr_done", {31'd0, done}, 1);
        drain("rr_drain");

        // ABORT with valid high after two of eight beats.
        w0 = n_writes;
        push_exp(1'b1, 2'b00, 12'h800, 32'hAB00_0000);
        push_exp(1'b1, 2'b00, 12'h804, 32'hAB00_0001);
        do_start(10'h200, 10'd8);
        run_mb(2, 10, 32'hAB00_0000, got, cyc);
        chk("abort_pre_beats", got, 2);
        mb_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("abort_mb_ready", {31'd0, mb_ready}, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        tick(ea, ma);
        chk("abort_mb_ready_idle", {31'd0, ma}, 0);
        mb_valid = 1'b0;
        chk("abort_idle", {30'd0, busy, done}, 0);
        drain("abort_drain");
        chk("abort_writes", n_writes - w0, 2);

        // Dword pointer wrap from 1023.
        push_exp(1'b1, 2'b00, 12'hFF8, 32'hEE00_0000);
        push_exp(1'b1, 2'b00, 12'hFFC, 32'hEE00_0001);
        if (WRAP_N == 4) begin
            push_exp(1'b1, 2'b00, 12'h000, 32'hEE00_0002);
            push_exp(1'b1, 2'b00, 12'h004, 32'hEE00_0003);
        end
        do_start(10'd1022, 10'd4);
        run_mb(4, 8, 32'hEE00_0000, got, cyc);
        chk("wrap_beats", got, WRAP_N);
        chk("wrap_done", {31'd0, done}, 1);
        chk("wrap_err", {31'd0, err}, {31'd0, WRAP_ERR});
        drain("wrap_drain");

        // LEN=0 goes straight to DONE; START during RUN is ignored.
        w0 = n_writes;
        do_start(10'h155, 10'd0);
        chk("len0_done", {30'd0, busy, done}, 32'd1);
        chk("len0_err_clr", {31'd0, err}, 0);
        tick(ea, ma);
        chk("len0_no_write", n_writes - w0, 0);
        push_exp(1'b1, 2'b00, 12'hC00, 32'h1100_0000);
        push_exp(1'b1, 2'b00, 12'hC04, 32'h1100_0001);
        push_exp(1'b1, 2'b00, 12'hC08, 32'h1100_0002);
        do_start(10'h300, 10'd3);
        run_mb(1, 5, 32'h1100_0000, got, cyc);
        do_start(10'h000, 10'd9);
        chk("restart_busy", {31'd0, busy}, 1);
        run_mb(2, 5, 32'h1100_0001, got, cyc);
        chk("restart_beats", got, 2);
        chk("restart_done", {31'd0, done}, 1);
        drain("restart_drain");

        // MB_PRIO=1 instance: math block wins every tie until DONE.
        p1_len = 10'd3; p1_start = 1'b1;
        tick(ea, ma);
        p1_start = 1'b0;
        p1_ef_valid = 1'b1; p1_mb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("prio_mb_c%0d", i), {31'd0, p1_mb_ready}, {31'd0, i < 3});
            chk($sformatf("prio_ef_c%0d", i), {31'd0, p1_ef_ready}, {31'd0, i == 3});
            @(posedge clk); #1;
        end
        p1_ef_valid = 1'b0; p1_mb_valid = 1'b0;
        chk("prio_done", {31'd0, p1_done}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
